// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB slave backed by a word-addressed register memory.
// - Byte-strobed writes through PSTRB.
// - PSLVERR for misaligned, out-of-range or strobe-inconsistent accesses.
// - Flags an ACCESS phase that arrives without a preceding SETUP phase
//   (protocol error) with PREADY=1 and PSLVERR=1 in that same cycle.
// Optional feature, selected by the macro APB_SLV_WAIT_EN:
// - Defined: WAIT_CYCLES wait states are inserted in every transfer.
// - Undefined: no wait counter, and every transfer completes in its first ACCESS cycle.
module apb_mem_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [3:0]        PSTRB,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Registered state only needs to remember whether the previous cycle
  // opened or continued a transfer (IDLE or ACCESS). The SETUP phase is
  // recognised directly from the bus, because the slave must sample the
  // request at the closing edge of that same cycle.
  logic [1:0]        state;
  logic [1:0]        phase;
  logic              err_q;
  logic              err_dec;
  logic              proto_err;
  logic              acc_ready;
  logic              commit;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Current bus phase, combining the bus signals with registered state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    phase = IDLE;
    if (PSEL && !PENABLE) begin
      phase = SETUP;
    end else if (PSEL && PENABLE && (state == ACCESS)) begin
      phase = ACCESS;
    end
  end

  // Request decode, valid while the address phase is on the bus.
  always_comb begin
    idx     = PADDR[2 +: IDX_W];
    err_dec = (PADDR[1:0] != 2'b00)
            || (PADDR[ADDR_W-1:IDX_W+2] != '0)
            || ( PWRITE && (PSTRB == 4'b0000))
            || (!PWRITE && (PSTRB != 4'b0000));
  end

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [3:0] wait_cnt;

  // Wait-state counter: loaded at the end of SETUP, drained during ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: clocked state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!PRESETn) begin
      wait_cnt <= 4'd0;
    end else if (phase == SETUP) begin
      wait_cnt <= WAIT_INIT;
    end else if ((phase == ACCESS) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign acc_ready = (wait_cnt == 4'd0);
`else
  assign acc_ready = 1'b1;
`endif

  // Response decode. The reset term keeps both outputs low while PRESETn
  // is asserted, even if the master still holds PSEL and PENABLE high.
  always_comb begin
    proto_err = PRESETn && PSEL && PENABLE && (state == IDLE);
    PREADY    = ((phase == ACCESS) && acc_ready) || proto_err;
    PSLVERR   = ((phase == ACCESS) && acc_ready && err_q) || proto_err;
    commit    = (phase == ACCESS) && acc_ready && PWRITE && !err_q;
  end

  // Phase tracking: SETUP opens a transfer, completion or a dropped PSEL ends it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else if (phase == SETUP) begin
      state <= ACCESS;
    end else if ((phase == ACCESS) && !acc_ready) begin
      state <= ACCESS;
    end else begin
      state <= IDLE;
    end
  end

  // Error flag captured at the end of SETUP and held for the ACCESS cycles.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_q <= 1'b0;
    end else if (phase == SETUP) begin
      err_q <= err_dec;
    end
  end

  // Read data is fetched at the end of a read SETUP and held until the next one.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA <= '0;
    end else if ((phase == SETUP) && !PWRITE) begin
      PRDATA <= err_dec ? '0 : mem[idx];
    end
  end

  // Storage array with byte-lane write enables, committed on the completing edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: the storage must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (PSTRB[i]) begin
          mem[idx][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

endmodule
